// File: rtl/twofish_stream_ctrl.sv
// rtl/twofish_stream_ctrl.sv - word-serial stream front/back end for the Twofish datapath core
// Optional busy watchdog enabled by defining TWOFISH_STREAM_TIMEOUT_EN.
module twofish_stream_ctrl
`ifdef TWOFISH_STREAM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 4096
)
`endif
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         ende_in,
    input  logic [127:0] key,
    output logic [127:0] core_block,
    output logic [127:0] core_key,
    output logic         core_ende,
    output logic         core_start,
    input  logic         core_busy,
    input  logic [127:0] core_o,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         error,
    output logic [15:0]  blocks_done
);

    typedef enum logic [2:0] {LOAD, START, WAIT_HI, WAIT_LO, DRAIN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   in_idx_q, in_idx_d;
    logic [1:0]   out_idx_q, out_idx_d;
    logic [127:0] block_q, block_d;
    logic [127:0] key_q, key_d;
    logic [127:0] res_q, res_d;
    logic         ende_q, ende_d;
    logic [15:0]  done_q, done_d;

`ifdef TWOFISH_STREAM_TIMEOUT_EN
    logic         err_q, err_d;
    logic [31:0]  tmo_q, tmo_d;
    logic         tmo_hit;

    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        block_d   = block_q;
        key_d     = key_q;
        res_d     = res_q;
        ende_d    = ende_q;
        done_d    = done_q;
`ifdef TWOFISH_STREAM_TIMEOUT_EN
        err_d     = err_q;
        tmo_d     = tmo_q;
        if (state_q == WAIT_HI || state_q == WAIT_LO) begin
            tmo_d = tmo_q + 32'd1;
        end
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    case (in_idx_q)
                        2'd0:    block_d[127:96] = in_data;
                        2'd1:    block_d[95:64]  = in_data;
                        2'd2:    block_d[63:32]  = in_data;
                        default: block_d[31:0]   = in_data;
                    endcase
                    if (in_idx_q == 2'd0) begin
                        ende_d = ende_in;
                    end
                    in_idx_d = in_idx_q + 2'd1;
                    if (in_idx_q == 2'd3) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                key_d   = key;
`ifdef TWOFISH_STREAM_TIMEOUT_EN
                err_d   = 1'b0;
                tmo_d   = 32'd0;
`endif
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // A low busy here is the core not having started yet, never completion.
                if (core_busy) begin
                    state_d = WAIT_LO;
                end
`ifdef TWOFISH_STREAM_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end
`endif
            end
            WAIT_LO: begin
                if (!core_busy) begin
                    res_d   = core_o;
                    done_d  = done_q + 16'd1;
                    state_d = DRAIN;
                end
`ifdef TWOFISH_STREAM_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end
`endif
            end
            DRAIN: begin
                if (out_ready) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= LOAD;
            in_idx_q  <= 2'd0;
            out_idx_q <= 2'd0;
            block_q   <= '0;
            key_q     <= '0;
            res_q     <= '0;
            ende_q    <= 1'b0;
            done_q    <= 16'd0;
`ifdef TWOFISH_STREAM_TIMEOUT_EN
            err_q     <= 1'b0;
            tmo_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            block_q   <= block_d;
            key_q     <= key_d;
            res_q     <= res_d;
            ende_q    <= ende_d;
            done_q    <= done_d;
`ifdef TWOFISH_STREAM_TIMEOUT_EN
            err_q     <= err_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign core_start  = (state_q == START);
    assign out_valid   = (state_q == DRAIN);
    assign core_block  = block_q;
    assign core_key    = key_q;
    assign core_ende   = ende_q;
    assign blocks_done = done_q;
`ifdef TWOFISH_STREAM_TIMEOUT_EN
    assign error       = err_q;
`else
    assign error       = 1'b0;
`endif

    always_comb begin
        out_data = 32'd0;
        if (state_q == DRAIN) begin
            case (out_idx_q)
                2'd0:    out_data = res_q[127:96];
                2'd1:    out_data = res_q[95:64];
                2'd2:    out_data = res_q[63:32];
                default: out_data = res_q[31:0];
            endcase
        end
    end

endmodule

// File: tb/tb_twofish_stream_ctrl.sv
// tb/tb_twofish_stream_ctrl.sv - self-checking bench for twofish_stream_ctrl
// Watchdog scenario is compiled only when TWOFISH_STREAM_TIMEOUT_EN is defined.
module tb_twofish_stream_ctrl;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ende_in;
    logic [127:0] key;
    logic [127:0] core_block;
    logic [127:0] core_key;
    logic         core_ende;
    logic         core_start;
    logic         core_busy;
    logic [127:0] core_o;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         error;
    logic [15:0]  blocks_done;

    always #5 Clk = ~Clk;

`ifdef TWOFISH_STREAM_TIMEOUT_EN
    twofish_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
    twofish_stream_ctrl dut (
`endif
        .Clk(Clk), .Reset(Reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ende_in(ende_in),
        .key(key), .core_block(core_block), .core_key(core_key), .core_ende(core_ende),
        .core_start(core_start), .core_busy(core_busy), .core_o(core_o),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .error(error), .blocks_done(blocks_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: assembled input blocks, expected output words, completed count.
    logic [31:0]  exp_q[$];
    logic [127:0] blk_q[$];
    logic         bende_q[$];
    logic [127:0] asm_blk;
    logic         asm_ende;
    int           widx, model_done, gen;
    int           last_word_cyc, fall_cyc, out_cnt;
    bit           pend_first, prev_busy, prev_out_valid, prev_start;
    bit           chk_ready_next, chk_key_next;
    logic [127:0] key_sampled;

    // Core model: busy rises core_dly cycles after start, stays high core_len cycles.
    logic [127:0] next_res;
    int           core_dly = 2;
    int           core_len = 16;
    bit           core_en  = 1'b1;
    int           cg;
    logic [127:0] cr;

    always begin
        @(negedge Clk);
        if (!Reset && core_start && core_en) begin
            cg = gen;
            cr = next_res;
            core_o = ~cr;
            repeat (core_dly) @(posedge Clk);
            #1 core_busy = 1'b1;
            repeat (core_len) @(posedge Clk);
            #1 core_busy = 1'b0;
            core_o = cr;
            if (cg == gen) begin
                exp_q.push_back(cr[127:96]);
                exp_q.push_back(cr[95:64]);
                exp_q.push_back(cr[63:32]);
                exp_q.push_back(cr[31:0]);
                model_done++;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            exp_q.delete();
            blk_q.delete();
            bende_q.delete();
            widx = 0; model_done = 0; out_cnt = 0; gen++;
            pend_first = 0; chk_ready_next = 0; chk_key_next = 0;
            prev_out_valid = 0; prev_start = 0;
        end else begin
            if (in_valid && in_ready) begin
                asm_blk[127 - 32*widx -: 32] = in_data;
                if (widx == 0) asm_ende = ende_in;
                if (widx == 3) begin
                    blk_q.push_back(asm_blk);
                    bende_q.push_back(asm_ende);
                    last_word_cyc = cyc;
                end
                widx = (widx + 1) % 4;
            end
            check("in_out_exclusive", in_ready & out_valid, 0);
            if (chk_key_next) begin
                check("core_key", core_key, key_sampled);
                chk_key_next = 0;
            end
            if (core_start) begin
                check("start_latency", cyc, last_word_cyc + 1);
                check("start_single", prev_start, 0);
                check("start_not_ready", in_ready, 0);
                if (blk_q.size() > 0) begin
                    check("core_block", core_block, blk_q.pop_front());
                    check("core_ende", core_ende, bende_q.pop_front());
                end else begin
                    check("start_without_block", 1, 0);
                end
                key_sampled = key;
                chk_key_next = 1;
            end
            if (chk_ready_next) begin
                check("in_ready_after_drain", in_ready, 1);
                chk_ready_next = 0;
            end
            if (out_valid && !prev_out_valid) begin
                check("out_after_busy_fall", pend_first, 1);
                check("out_latency", cyc, fall_cyc + 1);
                pend_first = 0;
            end
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                        if (out_cnt == 4) begin
                            chk_ready_next = 1;
                            out_cnt = 0;
                        end
                    end
                end else begin
                    check("unexpected_out_valid", out_valid, 0);
                end
            end
            if (in_ready || out_valid) check("blocks_done", blocks_done, 16'(model_done));
`ifndef TWOFISH_STREAM_TIMEOUT_EN
            check("error_tied_low", error, 0);
`endif
            if (prev_busy && !core_busy) begin
                fall_cyc = cyc;
                pend_first = 1;
            end
            prev_out_valid = out_valid;
            prev_start = core_start;
        end
        prev_busy = core_busy;
    end

    logic [31:0] got[4];
    int          got_n;

    task automatic send_word(input logic [31:0] d, input logic e);
        bit ok = 0;
        in_data = d; ende_in = e; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (in_ready) begin ok = 1; break; end
        end
        check("send_timeout", ok, 1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b, input logic e, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_word(b[127 - 32*i -: 32], (i == 0) ? e : ~e);
            if (i == 1 && gap > 0) begin
                repeat (gap) @(posedge Clk);
                #1;
            end
        end
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (core_start) begin ok = 1; break; end
        end
        check("start_timeout", ok, 1);
    endtask

    task automatic drain(input logic [7:0] pat, input int plen);
        int k = 0;
        got_n = 0;
        out_ready = pat[0];
        for (int c = 0; c < 400 && got_n < 4; c++) begin
            @(negedge Clk);
            if (out_valid) begin
                if (out_ready) begin
                    got[got_n] = out_data;
                    got_n++;
                end
                k++;
            end
            @(posedge Clk); #1;
            out_ready = (k < plen) ? pat[k] : 1'b1;
        end
        check("drain_complete", got_n, 4);
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] RES_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] BLK_B = 128'h10203040_50607080_90A0B0C0_D0E0F000;
    localparam logic [127:0] RES_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    initial begin
        Reset = 1'b1; in_valid = 0; in_data = 0; ende_in = 0; key = '0;
        core_busy = 0; core_o = '0; out_ready = 1'b1; next_res = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_core_ende", core_ende, 0);
        check("rst_core_block", core_block, 0);
        check("rst_core_key", core_key, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_error", error, 0);
        check("rst_blocks_done", blocks_done, 0);

        // Block A: back-to-back words, encrypt, 16-cycle core, free-running sink
        @(posedge Clk); #1;
        key = 128'h000102030405060708090A0B0C0D0E0F;
        next_res = RES_A; core_dly = 2; core_len = 16;
        send_block(BLK_A, 1'b1, 0);
        wait_start();
        check("A_core_block", core_block, BLK_A);
        check("A_core_ende", core_ende, 1);
        drain(8'hFF, 0);
        check("A_word0", got[0], 32'hDEADBEEF);
        check("A_word1", got[1], 32'h01234567);
        check("A_word2", got[2], 32'h89ABCDEF);
        check("A_word3", got[3], 32'hCAFEF00D);
        @(negedge Clk);
        check("A_blocks_done", blocks_done, 1);

        // Block B: decrypt, 10-cycle gap after word 1, busy already high at WAIT_HI, stalled sink
        @(posedge Clk); #1;
        key = 128'hF0E0D0C0_B0A09080_70605040_30201000;
        next_res = RES_B; core_dly = 1; core_len = 5;
        send_block(BLK_B, 1'b0, 10);
        wait_start();
        check("B_core_block", core_block, BLK_B);
        check("B_core_ende", core_ende, 0);
        drain(8'b0101_1001, 7);
        check("B_word0", got[0], 32'h0F1E2D3C);
        check("B_word1", got[1], 32'h4B5A6978);
        check("B_word2", got[2], 32'h8796A5B4);
        check("B_word3", got[3], 32'hC3D2E1F0);
        @(negedge Clk);
        check("B_blocks_done", blocks_done, 2);

        // Block C: reset while waiting for busy to fall
        @(posedge Clk); #1;
        next_res = 128'h11111111_22222222_33333333_44444444; core_dly = 2; core_len = 16;
        send_block(BLK_A ^ BLK_B, 1'b1, 0);
        wait_start();
        repeat (6) @(posedge Clk);
        #2 Reset = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b0;
        @(negedge Clk);
        check("C_rst_busy_high", core_busy, 1);
        check("C_rst_in_ready", in_ready, 1);
        check("C_rst_core_start", core_start, 0);
        check("C_rst_out_valid", out_valid, 0);
        check("C_rst_blocks_done", blocks_done, 0);
        for (int k = 0; k < 100 && core_busy; k++) @(negedge Clk);
        check("C_busy_released", core_busy, 0);

        // Block D: normal operation after reset
        @(posedge Clk); #1;
        next_res = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0; core_dly = 2; core_len = 3;
        send_block(BLK_B, 1'b1, 0);
        wait_start();
        drain(8'b0000_0110, 3);
        check("D_word0", got[0], 32'hA5A5A5A5);
        check("D_word3", got[3], 32'hF0F0F0F0);
        @(negedge Clk);
        check("D_blocks_done", blocks_done, 1);

`ifdef TWOFISH_STREAM_TIMEOUT_EN
        // Block E: core never raises busy, watchdog aborts after 8 WAIT_HI cycles
        @(posedge Clk); #1;
        core_en = 1'b0;
        send_block(BLK_A, 1'b1, 0);
        wait_start();
        repeat (8) @(negedge Clk);
        check("E_still_waiting", in_ready, 0);
        check("E_no_error_yet", error, 0);
        @(negedge Clk);
        check("E_error_set", error, 1);
        check("E_back_to_load", in_ready, 1);
        check("E_no_out_valid", out_valid, 0);
        check("E_blocks_done", blocks_done, 1);

        // Block F: error clears with the next start
        @(posedge Clk); #1;
        core_en = 1'b1;
        next_res = RES_A; core_dly = 2; core_len = 4;
        send_block(BLK_B, 1'b0, 0);
        wait_start();
        check("F_error_held_at_start", error, 1);
        @(negedge Clk);
        check("F_error_cleared", error, 0);
        drain(8'hFF, 0);
        check("F_word1", got[1], 32'h01234567);
        @(negedge Clk);
        check("F_blocks_done", blocks_done, 2);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twofish_stream_ctrl.md
# twofish_stream_ctrl

Word-serial front/back end for the Twofish `datapath` core. It accepts a 128-bit block as four 32-bit words over a valid/ready stream and latches the cipher direction. It pulses `Start` to the core and tracks its `busy` handshake, then returns the 128-bit result as four 32-bit words over a second valid/ready stream. It sits between the NIOS-side transfer logic and `datapath`, so the processor no longer polls `busy` or writes four PIOs per block.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles spent waiting on core `busy` before abort (watchdog builds only).
- `Clk` in 1: system clock (MAX10_CLK1_50 domain).
- `Reset` in 1: asynchronous, active-high reset.
- `in_data` in 32: input block word; word 0 = block[127:96], word 3 = block[31:0].
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: controller can accept a word.
- `ende_in` in 1: direction, sampled with word 0 (1 = encrypt, 0 = decrypt).
- `key` in 128: cipher key, sampled on the `core_start` cycle.
- `core_block` out 128: block to core.
- `core_key` out 128: key to core.
- `core_ende` out 1: direction to core.
- `core_start` out 1: one-cycle start pulse to core.
- `core_busy` in 1: core busy.
- `core_o` in 128: core result, valid when `busy` falls.
- `out_data` out 32: result word; word 0 = o[127:96].
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: sink accepts word.
- `error` out 1: sticky timeout flag.
- `blocks_done` out 16: count of completed blocks.

## Operation
- States: LOAD, START, WAIT_HI, WAIT_LO, DRAIN.
- LOAD:
  - `in_ready`=1; word accepted on `in_valid & in_ready`; 2-bit word index 0..3.
  - Word k is written to `core_block` slice k; `ende_in` is latched into `core_ende` on word 0.
  - After word 3 is accepted → START.
- START:
  - `core_start`=1 for exactly one cycle; `key` latched into `core_key`; `error` cleared; timeout counter cleared → WAIT_HI.
- WAIT_HI: `core_busy`=1 → WAIT_LO.
- WAIT_LO: `core_busy`=0 → capture `core_o` into the 128-bit output register; `blocks_done`+1, wrapping 0xFFFF→0 → DRAIN.
- DRAIN:
  - `out_valid`=1; `out_data` = word selected by output index.
  - The index advances on `out_valid & out_ready`.
  - After word 3 is accepted → LOAD.
- `in_ready` is 0 in every state except LOAD. Input is never accepted while the core runs or output drains.
- `core_block`, `core_key` and `core_ende` stay stable from START until the next LOAD word 0.
- `in_valid` may drop mid-block; partial blocks are held indefinitely; the index is not reset.
- Reset (any state) returns to LOAD with all indices zero. The output register is zeroed.
- Reset values:
  - `in_ready`=1 (LOAD)
  - `core_start`=0, `core_ende`=0
  - `core_block`=0, `core_key`=0
  - `out_valid`=0, `out_data`=0
  - `error`=0, `blocks_done`=0

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `in_valid` or `out_ready` to outputs.
- Word 3 accepted at cycle t → `core_start`=1 at t+1 → WAIT_HI at t+2.
- `core_busy` already 1 at t+2 → WAIT_LO at t+3. Busy must be seen high before a low is honoured; a 0 in WAIT_HI is never treated as completion.
- `core_busy` sampled 0 in WAIT_LO at cycle c:
  - `out_valid`=1 with word 0 at c+1.
  - `blocks_done` updated at c+1.
- Full duplex is not supported. Minimum block period = 4 (load) + 1 (start) + core latency + 2 + 4 (drain) cycles.
- With `out_ready` held 1, the four output words appear on consecutive cycles; `in_ready`=1 on the cycle after word 3 is accepted.

## Configuration
- `TWOFISH_STREAM_TIMEOUT_EN` defined:
  - A counter runs in WAIT_HI/WAIT_LO.
  - On reaching `TIMEOUT_CYCLES`: set `error`=1, discard the result, leave `blocks_done` unchanged, → LOAD.
  - `error` holds until the next START or `Reset`.
- Not defined: no counter; WAIT states wait indefinitely; `error` tied 0.

## Test plan
- Reset mid-WAIT_LO with `core_busy`=1 → next cycle: LOAD, `in_ready`=1, `core_start`=0, `out_valid`=0, `blocks_done`=0.
- Stream words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with `ende_in`=1 → `core_block`=0x00112233_44556677_8899AABB_CCDDEEFF, `core_ende`=1, single-cycle `core_start` one cycle after the last word.
- Model core: busy high 2 cycles after start for 16 cycles with `core_o`=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D → `out_data` sequence DEADBEEF, 01234567, 89ABCDEF, CAFEF00D; `blocks_done`=1.
- Toggle `out_ready` 1,0,0,1,1,0,1 during DRAIN → no word dropped or duplicated; `in_ready` stays 0 until the fourth acceptance.
- `in_valid` gaps between words 1 and 2 (10 idle cycles), and `core_busy` already 1 at WAIT_HI entry → block assembled correctly; completion only after busy falls.
- Watchdog build, `TIMEOUT_CYCLES`=8, `core_busy` stuck at 0 → `error`=1 after 8 WAIT_HI cycles, LOAD entered, no `out_valid`, `blocks_done` unchanged; `error` clears on the next `core_start`.
